// File: rtl/vram_write_scheduler_if.sv
// vram_write_scheduler_if: requester handshakes and VRAM port A write bus
// master: requesters and VRAM side (drives valid/ofs/data, observes ready and port A)
// slave : the scheduler (drives ready and port A addr/data/we)
interface vram_write_scheduler_if #(parameter int ADDR_W = 18);
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_ofs;
    logic [7:0]        req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_ofs;
    logic [7:0]        req1_data;
    logic              req1_ready;
    logic [ADDR_W-1:0] addr_a;
    logic [7:0]        data_a;
    logic              we_a;
    modport master (
        output req0_valid, req0_ofs, req0_data, req1_valid, req1_ofs, req1_data,
        input  req0_ready, req1_ready, addr_a, data_a, we_a
    );
    modport slave (
        input  req0_valid, req0_ofs, req0_data, req1_valid, req1_ofs, req1_data,
        output req0_ready, req1_ready, addr_a, data_a, we_a
    );
endinterface

// File: rtl/vram_write_scheduler.sv
// vram_write_scheduler: arbitrates two byte-write requesters into the back buffer and swaps buffers on vsync
// Ports: clk, rst_n (async active low); bus (slave: req0/req1 valid/ofs/data/ready, VRAM port A addr/data/we);
//        swap_req, vsync in; swap_done pulse, front_base, back_base, err_oob (sticky) out.
// Optional VRAM_CLEAR_EN: adds CLEAR_VALUE, clear_req in, clear_busy and clear_done (pulse) out,
//        and a CLEAR state that fills the back buffer one byte per cycle.
module vram_write_scheduler #(
    parameter int FRAME_BYTES = 49152,
    parameter int BASE0       = 0,
    parameter int BASE1       = 49152,
    parameter int ADDR_W      = 18
`ifdef VRAM_CLEAR_EN
    , parameter logic [7:0] CLEAR_VALUE = 8'h00
`endif
) (
    input  logic                 clk,
    input  logic                 rst_n,
    vram_write_scheduler_if.slave bus,
    input  logic                 swap_req,
    input  logic                 vsync,
    output logic                 swap_done,
    output logic [ADDR_W-1:0]    front_base,
    output logic [ADDR_W-1:0]    back_base,
    output logic                 err_oob
`ifdef VRAM_CLEAR_EN
    , input  logic               clear_req,
    output logic                 clear_busy,
    output logic                 clear_done
`endif
);
    typedef enum logic [1:0] {
        RUN,
        PEND
`ifdef VRAM_CLEAR_EN
        , CLEAR
`endif
    } state_t;

    localparam logic [ADDR_W-1:0] B0   = ADDR_W'(BASE0);
    localparam logic [ADDR_W-1:0] B1   = ADDR_W'(BASE1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);

    state_t            state, state_n;
    logic              sel, rr, g0, g1, xfer, in_range;
    logic [ADDR_W-1:0] ofs;
    logic [7:0]        dat;
`ifdef VRAM_CLEAR_EN
    logic [ADDR_W-1:0] cnt;
    logic              swap_lat;
    assign clear_busy = state == CLEAR;
`endif

    assign front_base     = sel ? B1 : B0;
    assign back_base      = sel ? B0 : B1;
    assign bus.req0_ready = g0;
    assign bus.req1_ready = g1;
    assign xfer           = g0 || g1;
    assign ofs            = g1 ? bus.req1_ofs : bus.req0_ofs;
    assign dat            = g1 ? bus.req1_data : bus.req0_data;
    assign in_range       = ofs <= LAST;

    // rr is the requester granted last; under contention the other one wins
    always_comb begin
        state_n = state;
        g0 = 1'b0;
        g1 = 1'b0;
        if (state == RUN) begin
            g0 = bus.req0_valid && (!bus.req1_valid || rr);
            g1 = bus.req1_valid && (!bus.req0_valid || !rr);
`ifdef VRAM_CLEAR_EN
            state_n = clear_req ? CLEAR : swap_req ? PEND : RUN;
`else
            state_n = swap_req ? PEND : RUN;
`endif
        end else if (state == PEND) begin
            state_n = vsync ? RUN : PEND;
        end
`ifdef VRAM_CLEAR_EN
        else if (cnt == LAST) begin
            state_n = (swap_lat || swap_req) ? PEND : RUN;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= RUN;
        else        state <= state_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel        <= 1'b0;
            rr         <= 1'b1;
            swap_done  <= 1'b0;
            err_oob    <= 1'b0;
            bus.we_a   <= 1'b0;
            bus.addr_a <= '0;
            bus.data_a <= '0;
`ifdef VRAM_CLEAR_EN
            cnt        <= '0;
            swap_lat   <= 1'b0;
            clear_done <= 1'b0;
`endif
        end else begin
            swap_done <= state == PEND && vsync;
            if (state == PEND && vsync) sel <= !sel;
            if (xfer) rr <= g1;
            err_oob  <= err_oob || (xfer && !in_range);
            bus.we_a <= xfer && in_range;
            if (xfer && in_range) begin
                bus.addr_a <= back_base + ofs;
                bus.data_a <= dat;
            end
`ifdef VRAM_CLEAR_EN
            // a swap requested alongside or during a clear is held until the clear finishes
            cnt        <= state == CLEAR ? cnt + 1'b1 : '0;
            clear_done <= state == CLEAR && cnt == LAST;
            swap_lat   <= state == CLEAR ? (swap_lat || swap_req) : (state == RUN && clear_req && swap_req);
            if (state == CLEAR) begin
                bus.we_a   <= 1'b1;
                bus.addr_a <= back_base + cnt;
                bus.data_a <= CLEAR_VALUE;
            end
`endif
        end
    end
endmodule

// File: doc/vram_write_scheduler.md
Name: vram_write_scheduler

Overview:
- Single-clock controller owning VRAM port A (write side) for double-buffered frames.
- Arbitrates byte writes from two requesters (rasterizer = REQ0, host = REQ1) into the current back buffer.
- Sequences front/back buffer swaps on VSYNC and publishes FRONT_BASE to the scanout engine that reads port B.

Parameters:
- FRAME_BYTES, 49152, bytes per frame buffer; legal offsets are 0..FRAME_BYTES-1.
- BASE0, 0, VRAM byte address of buffer 0.
- BASE1, 49152, VRAM byte address of buffer 1.
- ADDR_W, 18, VRAM address width.

Ports:
- CLK  in  1  clock, rising edge.
- RST_N  in  1  asynchronous reset, active low.
- REQ0_VALID  in  1  requester 0 has a write.
- REQ0_OFS  in  ADDR_W  byte offset within the back buffer.
- REQ0_DATA  in  8  write byte.
- REQ0_READY  out  1  requester 0 granted this cycle.
- REQ1_VALID / REQ1_OFS / REQ1_DATA / REQ1_READY: same as requester 0.
- SWAP_REQ  in  1  pulse: request a buffer swap.
- VSYNC  in  1  pulse: start of vertical blank.
- SWAP_DONE  out  1  one-cycle pulse when a swap takes effect.
- FRONT_BASE  out  ADDR_W  base address of the displayed buffer.
- BACK_BASE  out  ADDR_W  base address of the drawn buffer.
- ADDR_A  out  ADDR_W  VRAM port A address.
- DATA_A  out  8  VRAM port A data.
- WE_A  out  1  VRAM port A write enable.
- ERR_OOB  out  1  sticky flag: an out-of-range offset was dropped.

Behaviour:
- Reset (async assert, sync release) sets:
  - buffer select 0, so FRONT_BASE=BASE0 and BACK_BASE=BASE1.
  - WE_A=0, ADDR_A=0, DATA_A=0, SWAP_DONE=0, ERR_OOB=0.
  - state RUN, round-robin pointer = 1 (REQ0 wins first contention).
- FSM states: RUN, PEND, plus CLEAR when the optional feature is compiled in.
- RUN:
  - READY is combinational. At most one READY is high per cycle.
  - Sole valid requester is granted.
  - If both are valid, grant the requester not granted last, then update the pointer.
  - A transfer occurs when VALID&&READY.
- Transfer:
  - Next cycle: WE_A=1, ADDR_A=BACK_BASE+OFS, DATA_A=DATA. Latency is 1 cycle, registered.
  - Otherwise WE_A=0. ADDR_A and DATA_A hold their last values.
- Out-of-range offset (OFS>=FRAME_BYTES):
  - The handshake still completes (READY high) and the pointer still updates.
  - WE_A stays 0 and ERR_OOB sets; it clears only on reset.
- SWAP_REQ in RUN: go to PEND next cycle. A VSYNC in the same cycle as SWAP_REQ does not count.
- PEND:
  - Both READY low. SWAP_REQ is ignored.
  - On VSYNC: toggle buffer select (FRONT_BASE and BACK_BASE exchange on the next edge), pulse SWAP_DONE for 1 cycle, return to RUN.
- A write granted in the cycle SWAP_REQ is seen still uses the old BACK_BASE.
- VSYNC in RUN without a pending swap has no effect.
- Reset mid-PEND discards the pending swap.

Optional Feature:
- Macro: VRAM_CLEAR_EN.
- Defined:
  - Adds parameter CLEAR_VALUE (8'h00) and ports CLEAR_REQ (in, 1), CLEAR_BUSY (out, 1), CLEAR_DONE (out, 1, pulse).
  - CLEAR_REQ in RUN enters CLEAR. CLEAR_REQ is ignored in PEND and CLEAR.
  - CLEAR writes CLEAR_VALUE to BACK_BASE+0 .. BACK_BASE+FRAME_BYTES-1, one byte per cycle (WE_A=1 each cycle), with both READY low and CLEAR_BUSY=1.
  - After the last byte: CLEAR_DONE pulses 1 cycle.
  - A SWAP_REQ received during CLEAR is latched; after the clear the FSM goes to PEND, otherwise back to RUN.
  - VSYNC during CLEAR has no effect.
  - If CLEAR_REQ and SWAP_REQ arrive together in RUN, CLEAR takes priority and the swap is latched.
- Undefined: none of these ports, parameter or state exist.

Test Plan:
- Reset, REQ0 writes OFS=5, DATA=8'hA5 -> one cycle later WE_A=1, ADDR_A=49157, DATA_A=8'hA5; FRONT_BASE=0.
- REQ0 and REQ1 both continuously valid for 4 cycles -> grants alternate 0,1,0,1; never both READY high.
- REQ1 OFS=49152 -> READY=1, WE_A stays 0, ERR_OOB=1, and it stays 1 afterward.
- SWAP_REQ, VSYNC 10 cycles later with REQ0 valid throughout -> READY0=0 for those cycles; SWAP_DONE pulses once; FRONT_BASE=49152, BACK_BASE=0; next write OFS=3 gives ADDR_A=3.
- SWAP_REQ and VSYNC in the same cycle -> no swap; the swap happens on the next VSYNC only.
- With VRAM_CLEAR_EN, FRAME_BYTES=16: CLEAR_REQ -> 16 consecutive WE_A cycles at ADDR_A 49152..49167 with DATA_A=0, then a CLEAR_DONE pulse; a SWAP_REQ issued mid-clear gives PEND afterward.
